// File: rtl/pcm_sample_feeder.sv
// pcm_sample_feeder
// Elastic buffer and sample-rate pacer that sits between the IFFT output and the
// 1-bit delta-sigma DAC. Bursty IFFT samples enter a circular FIFO through a
// valid/ready handshake. Every DIV clocks the pacer presents one PCM word to the
// DAC, together with a single-cycle load strobe. The FIFO pre-fills before
// playback starts. Underruns are padded with IDLE_WORD (DAC mid-scale) and latch
// a sticky underflow flag.

module pcm_sample_feeder #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 10,
  parameter int                 DIV       = 2268,
  parameter int                 PREFILL   = 512,
  parameter logic [DATA_W-1:0]  IDLE_WORD = 16'h8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] pcm_out,
  output logic              stb,
  output logic [ADDR_W:0]   level,
  output logic              running,
  output logic              underflow,
  input  logic              clr_flags
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [ADDR_W:0]  LVL_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  LVL_START = (ADDR_W + 1)'(PREFILL);

  typedef enum logic {
    S_FILL = 1'b0,  // collecting samples; the DAC receives IDLE_WORD
    S_RUN  = 1'b1   // one FIFO sample is popped per tick
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  div_cnt;

  logic tick;
  logic wr_en;
  logic pop;
  logic set_uf;

  // Handshake and pacing qualifiers.
  // A flush cycle discards the write of that cycle.
  assign in_ready = (level != LVL_FULL);
  assign wr_en    = in_valid && in_ready && !flush;
  assign tick     = enable && (div_cnt == DIV_LAST);
  assign running  = (state_q == S_RUN);

  // Sample-period counter. It is frozen while enable is low and survives a flush.
  // NOTE: every always_ff uses non-blocking assignments, so all registers update
  // together from the values they held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;
    end
  end

  // FSM next state and pop decision. The decision is taken only on a tick.
  // NOTE: each output of this block gets a default before any branch, so that
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    set_uf  = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_FILL: begin
          if (level >= LVL_START) begin
            pop     = 1'b1;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (level != '0) begin
            pop = 1'b1;
          end else begin
            set_uf  = 1'b1;
            state_d = S_FILL;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
    // A flush cancels the pop of its cycle and restarts the pre-fill.
    if (flush) begin
      state_d = S_FILL;
      pop     = 1'b0;
      set_uf  = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // FIFO storage. The pointers and level decide which entries are valid.
  // NOTE: the sample array is deliberately left without a reset. Stale contents
  // are never read, and omitting the reset lets the array map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  // Read/write pointers and occupancy. The pointers wrap naturally at DEPTH.
  // When a write and a pop occur together, the level does not change.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // DAC interface. On every tick, register either the popped sample or the idle
  // word and pulse the strobe one cycle later. A flush keeps the held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcm_out <= IDLE_WORD;
      stb     <= 1'b0;
    end else begin
      stb <= tick;
      if (tick && !flush) begin
        pcm_out <= pop ? mem[rd_ptr] : IDLE_WORD;
      end
    end
  end

  // Sticky underflow flag. If a new underflow and clr_flags coincide, the set wins.
  always_ff @(posedge clk) begin
    if (rst)            underflow <= 1'b0;
    else if (set_uf)    underflow <= 1'b1;
    else if (clr_flags) underflow <= 1'b0;
  end

endmodule

// File: tb/tb_pcm_sample_feeder.sv
// Directed bench for pcm_sample_feeder with DIV=8, ADDR_W=3 and PREFILL=4.
// Inputs are driven and outputs sampled on the falling edge of clk.

module tb_pcm_sample_feeder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam logic [15:0] IDLE = 16'h8000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] pcm_out;
  logic              stb;
  logic [ADDR_W:0]   level;
  logic              running;
  logic              underflow;
  logic              clr_flags = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pcm_sample_feeder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV(8), .PREFILL(4), .IDLE_WORD(16'h8000)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .pcm_out(pcm_out), .stb(stb), .level(level), .running(running),
    .underflow(underflow), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; clr_flags = 1'b0; enable = en;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Step through falling edges until stb is seen, giving up after 40 cycles.
  task automatic wait_stb(output bit ok, output int at_cyc);
    ok = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stb) begin
        ok = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL stb_timeout: got no strobe within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  // Back-to-back writes, one per cycle. The FIFO must have room for all of them.
  task automatic write_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      in_data  = base + 16'(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    int          n_wr;       // words written right after this strobe
    logic [15:0] wr_base;
    logic [15:0] exp_pcm;    // expected values at this strobe
    logic        exp_run;
    logic        exp_uf;
    logic [3:0]  exp_level;
  } vec_t;

  vec_t vecs [9];

  bit   ok;
  int   t_stb;
  int   t_prev;
  int   drv_idx;
  int   n_stb;
  int   lat;
  logic lvl_changed;
  logic [15:0] exp_seq [24];

  initial begin
    // Expected strobes after reset, when 1..5 are written after the second strobe.
    vecs[0] = '{0, 16'h0000, IDLE,     1'b0, 1'b0, 4'd0};
    vecs[1] = '{5, 16'h0001, IDLE,     1'b0, 1'b0, 4'd0};
    vecs[2] = '{0, 16'h0000, 16'h0001, 1'b1, 1'b0, 4'd4};
    vecs[3] = '{0, 16'h0000, 16'h0002, 1'b1, 1'b0, 4'd3};
    vecs[4] = '{0, 16'h0000, 16'h0003, 1'b1, 1'b0, 4'd2};
    vecs[5] = '{0, 16'h0000, 16'h0004, 1'b1, 1'b0, 4'd1};
    vecs[6] = '{0, 16'h0000, 16'h0005, 1'b1, 1'b0, 4'd0};
    vecs[7] = '{0, 16'h0000, IDLE,     1'b0, 1'b1, 4'd0};
    vecs[8] = '{0, 16'h0000, IDLE,     1'b0, 1'b1, 4'd0};

    // ---- 1/2: reset state, idle pacing, prefill, playback, underflow ----
    do_reset(1'b1);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_pcm", 32'(pcm_out), 32'(IDLE));
    check("rst_level", 32'(level), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_underflow", 32'(underflow), 32'd0);

    t_prev = 0;
    for (int i = 0; i < 9; i++) begin
      wait_stb(ok, t_stb);
      if (ok) begin
        check($sformatf("v%0d_pcm", i), 32'(pcm_out), 32'(vecs[i].exp_pcm));
        check($sformatf("v%0d_running", i), 32'(running), 32'(vecs[i].exp_run));
        check($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_uf));
        check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
        if (i > 0) check($sformatf("v%0d_period", i), 32'(t_stb - t_prev), 32'd8);
        t_prev = t_stb;
      end
      write_words(vecs[i].n_wr, vecs[i].wr_base);
    end

    // clr_flags pulse away from a tick
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("clr_underflow", 32'(underflow), 32'd0);

    // ---- 3: backpressure on a full FIFO, then in-order drain ----
    do_reset(1'b0);
    write_words(8, 16'h0000);
    in_data  = 16'd8;
    in_valid = 1'b1;
    lvl_changed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || level !== 4'd8) lvl_changed = 1'b1;
    end
    check("full_stall", 32'(lvl_changed), 32'd0);
    check("full_level", 32'(level), 32'd8);
    enable = 1'b1;
    drv_idx = 8;
    fork
      begin
        for (int g = 0; g < 400 && drv_idx < 10; g++) begin
          logic acc;
          in_data  = 16'(drv_idx);
          in_valid = 1'b1;
          acc = in_ready;
          @(negedge clk);
          if (acc) drv_idx++;
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          wait_stb(ok, t_stb);
          if (ok) check($sformatf("order_%0d", k), 32'(pcm_out), k);
        end
      end
    join
    check("stalled_accepted", drv_idx, 10);

    // ---- 4: write on the tick cycle with level 4, then pointer wrap ----
    do_reset(1'b0);
    write_words(5, 16'hA000);
    enable = 1'b1;
    wait_stb(ok, t_stb);
    check("t4_first_pcm", 32'(pcm_out), 32'hA000);
    check("t4_level4", 32'(level), 32'd4);
    repeat (7) @(negedge clk);
    in_data  = 16'hB000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("tick_wr_stb", 32'(stb), 32'd1);
    check("tick_wr_pcm", 32'(pcm_out), 32'hA001);
    check("tick_wr_level", 32'(level), 32'd4);
    exp_seq[0] = 16'hA002;
    exp_seq[1] = 16'hA003;
    exp_seq[2] = 16'hA004;
    exp_seq[3] = 16'hB000;
    for (int i = 0; i < 20; i++) exp_seq[4 + i] = 16'hC000 + 16'(i);
    drv_idx = 0;
    fork
      begin
        for (int g = 0; g < 400 && drv_idx < 20; g++) begin
          logic acc;
          in_data  = 16'hC000 + 16'(drv_idx);
          in_valid = 1'b1;
          acc = in_ready;
          @(negedge clk);
          if (acc) drv_idx++;
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 24; k++) begin
          wait_stb(ok, t_stb);
          if (ok) check($sformatf("wrap_%0d", k), 32'(pcm_out), 32'(exp_seq[k]));
        end
      end
    join
    check("wrap_no_underflow", 32'(underflow), 32'd0);

    // ---- 5: enable low for 30 cycles mid-RUN ----
    do_reset(1'b0);
    write_words(6, 16'hD000);
    enable = 1'b1;
    wait_stb(ok, t_stb);
    check("t5_first_pcm", 32'(pcm_out), 32'hD000);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    n_stb = 0;
    lvl_changed = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (stb) n_stb++;
      if (level !== 4'd5) lvl_changed = 1'b1;
    end
    check("frozen_no_stb", n_stb, 0);
    check("frozen_level", 32'(lvl_changed), 32'd0);
    check("frozen_running", 32'(running), 32'd1);
    enable = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (stb) begin
        lat = c;
        break;
      end
    end
    check("reenable_latency", lat, 5);
    check("reenable_pcm", 32'(pcm_out), 32'hD001);

    // ---- 6: flush in RUN with level 6, then reset mid-burst ----
    do_reset(1'b0);
    write_words(7, 16'hE000);
    enable = 1'b1;
    wait_stb(ok, t_stb);
    check("t6_level6", 32'(level), 32'd6);
    check("t6_running", 32'(running), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_running", 32'(running), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_pcm_kept", 32'(pcm_out), 32'hE000);
    wait_stb(ok, t_stb);
    check("flush_idle_pcm", 32'(pcm_out), 32'(IDLE));
    check("flush_no_underflow", 32'(underflow), 32'd0);
    write_words(4, 16'hF000);
    wait_stb(ok, t_stb);
    check("t6_run_pcm", 32'(pcm_out), 32'hF000);
    check("t6_run_level", 32'(level), 32'd3);
    in_data = 16'hF010; in_valid = 1'b1;
    @(negedge clk);
    in_data = 16'hF011;
    @(negedge clk);
    in_data = 16'hF012; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_pcm", 32'(pcm_out), 32'(IDLE));
    check("midrst_stb", 32'(stb), 32'd0);
    wait_stb(ok, t_stb);
    check("midrst_next_pcm", 32'(pcm_out), 32'(IDLE));
    check("midrst_next_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
